pll_lock_sequencer: RTL
=======================

# pll_lock_sequencer

Reset and lock sequencer for the clocking PLL. It drives the PLL reset, qualifies the asynchronous `locked` indication, and retries on lock timeout. It releases the system reset only after lock has been continuously stable. It sits between the board reset/refclk input and the PLL instance, and its `sys_rst`/`ready` outputs gate the DDR3, camera and HDMI domains.

## Interface
Parameters:
- `RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before `ready` (≥2).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed from PLL reset release to `ready` before a retry (> `LOCK_STABLE_CYCLES`+2).
- `MAX_RETRIES`, 3: consecutive failed attempts before FAULT (only with `PLL_SEQ_FAULT_EN`; 1..15).

Ports:
- `refclk`, in, 1: sole clock (50 MHz board reference).
- `rst`, in, 1: asynchronous, active-high reset.
- `locked`, in, 1: PLL lock, asynchronous to `refclk`.
- `restart`, in, 1: synchronous single-cycle request to re-run the sequence.
- `pll_rst`, out, 1: PLL reset, active-high.
- `sys_rst`, out, 1: downstream reset, active-high; always equals `~ready`.
- `ready`, out, 1: PLL locked and qualified.
- `lock_lost`, out, 1: one-cycle pulse when lock drops in RUN.
- `fault`, out, 1: retry limit exhausted.
- `retry_cnt`, out, 4: consecutive failed attempts, saturating at 15.

## Operation
- `locked` passes through a 2-flop synchronizer (reset value 0) to give `locked_s`. All decisions use `locked_s` only.
- **RESET_HOLD**
  - `pll_rst`=1, `hold_cnt` increments.
  - When `hold_cnt`==`RST_CYCLES`-1: go to WAIT_LOCK and clear `tmo_cnt`.
- **WAIT_LOCK**
  - `pll_rst`=0, `tmo_cnt` increments.
  - When `locked_s`=1: go to STABLE and clear `stab_cnt`.
- **STABLE**
  - `tmo_cnt` keeps incrementing. `stab_cnt` increments while `locked_s`=1.
  - `locked_s`=0: return to WAIT_LOCK. `tmo_cnt` is not cleared, so a chattering lock still times out.
  - `stab_cnt`==`LOCK_STABLE_CYCLES`-1: go to RUN.
- **Timeout** (WAIT_LOCK or STABLE, `tmo_cnt`==`LOCK_TIMEOUT_CYCLES`-1)
  - Counts as a failed attempt: `retry_cnt` increments, saturating.
  - Next state is RESET_HOLD, or FAULT (see Configuration).
  - If STABLE completion and timeout occur in the same cycle, RUN wins.
- **RUN**
  - `ready`=1, `sys_rst`=0, `retry_cnt` cleared to 0.
  - `locked_s`=0: pulse `lock_lost` for one cycle and go to RESET_HOLD.
- **FAULT**
  - `pll_rst`=1, `sys_rst`=1, `fault`=1.
  - Exits only on `restart` or `rst`.
- **`restart`** in any state: go to RESET_HOLD, clear `hold_cnt`, `retry_cnt` and `fault`.
  - Takes priority over every other transition in that cycle.
  - Suppresses `lock_lost` in that cycle.
- Counters are sized $clog2 of their limit and are cleared on state entry. No counter ever wraps.

## Timing
- Reset values: state RESET_HOLD, `pll_rst`=1, `sys_rst`=1, `ready`=0, `lock_lost`=0, `fault`=0, `retry_cnt`=0, all counters 0.
- All outputs are registered and change on the same edge as the state transition.
- `pll_rst` is high for exactly `RST_CYCLES` edges per attempt.
- Nominal startup: the PLL raises `locked` at cycle L after `pll_rst` falls. `ready` rises at L+2 (synchronizer) + `LOCK_STABLE_CYCLES` cycles after `pll_rst` falls.
- A `locked` drop in RUN: `ready` falls and `lock_lost` pulses 3 edges after the drop (2 synchronizer + 1 state). `pll_rst` rises on that same edge.
- Asynchronous `rst` mid-operation returns everything to reset values immediately. The sequence restarts on the first edge after release.

## Configuration
- `PLL_SEQ_FAULT_EN` defined:
  - When a failure makes `retry_cnt` reach `MAX_RETRIES`, go to FAULT instead of RESET_HOLD.
  - `fault` stays latched until `restart` or `rst`.
- `PLL_SEQ_FAULT_EN` undefined:
  - FAULT state and logic are not compiled. Failures always go to RESET_HOLD and retry indefinitely.
  - `fault` is tied 0. `retry_cnt` still counts and saturates at 15.

## Test plan
Parameters for all scenarios: `RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `MAX_RETRIES`=2.
- **Nominal lock:** release `rst`; `locked` rises 5 cycles after `pll_rst` falls → `pll_rst` high 4 cycles; `ready`=1, `sys_rst`=0 exactly 5+2+8 cycles after `pll_rst` fall; `retry_cnt`=0.
- **Chattering lock:** `locked` toggles every 6 cycles → never reaches RUN; at `tmo_cnt`=31 `pll_rst` re-asserts and `retry_cnt`=1.
- **Retry limit with `PLL_SEQ_FAULT_EN`:** `locked` held 0 → after 2 timeouts `fault`=1 and `pll_rst`=1 held. `restart` pulse clears `fault` and `retry_cnt`=0. `locked`=1 then → RUN.
- **Retry limit without the macro:** same stimulus → `fault` stays 0; `retry_cnt` counts 1, 2, … and saturates at 15 after 15 timeouts; `pll_rst` keeps cycling.
- **Lock loss in RUN:** drop `locked` → 3 edges later `lock_lost` is a single-cycle pulse, `ready`=0, `pll_rst`=1 for 4 cycles. Re-lock → RUN again.
- **Simultaneous events:** `restart` in the same cycle as a lock drop in RUN → RESET_HOLD, no `lock_lost` pulse. Async `rst` mid-STABLE → all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies the synchronized lock
// indication for a stable window, retries on timeout and releases sys_rst once locked.
// Optional retry-limit FAULT state is compiled in when PLL_SEQ_FAULT_EN is defined.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  localparam int HoldW = $clog2(RST_CYCLES);
  localparam int StabW = $clog2(LOCK_STABLE_CYCLES);
  localparam int TmoW  = $clog2(LOCK_TIMEOUT_CYCLES);

  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_CYCLES - 1);
  localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(LOCK_TIMEOUT_CYCLES - 1);

  // Reject parameter sets that would let a counter wrap or the timeout preempt lock.
  if (RST_CYCLES < 2 || LOCK_STABLE_CYCLES < 2 ||
      LOCK_TIMEOUT_CYCLES <= LOCK_STABLE_CYCLES + 2 ||
      MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_param_err
    $error("pll_lock_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    StResetHold,
    StWaitLock,
    StStable,
`ifdef PLL_SEQ_FAULT_EN
    StFault,
`endif
    StRun
  } state_e;

  state_e           state;
  logic [HoldW-1:0] hold_cnt;
  logic [StabW-1:0] stab_cnt;
  logic [TmoW-1:0]  tmo_cnt;
  logic             locked_meta;
  logic             locked_s;
  logic [3:0]       retry_inc;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked;
      locked_s    <= locked_meta;
    end
  end

  // Failure count for the next attempt, saturating at 15.
  always_comb begin
    retry_inc = (retry_cnt == 4'd15) ? 4'd15 : retry_cnt + 4'd1;
  end

`ifdef PLL_SEQ_FAULT_EN
  localparam logic [3:0] RetryLimit = 4'(MAX_RETRIES);
  logic fault_q;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Sequencer FSM; every output is a register updated on the transition edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= StResetHold;
      hold_cnt  <= '0;
      stab_cnt  <= '0;
      tmo_cnt   <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= '0;
`ifdef PLL_SEQ_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      lock_lost <= 1'b0;
      if (restart) begin
        // Restart overrides everything, including a lock drop seen this cycle.
        state     <= StResetHold;
        hold_cnt  <= '0;
        retry_cnt <= '0;
        pll_rst   <= 1'b1;
        sys_rst   <= 1'b1;
        ready     <= 1'b0;
`ifdef PLL_SEQ_FAULT_EN
        fault_q   <= 1'b0;
`endif
      end else begin
        unique case (state)
          StResetHold: begin
            pll_rst <= 1'b1;
            if (hold_cnt == HoldLast) begin
              state   <= StWaitLock;
              tmo_cnt <= '0;
              pll_rst <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HoldW'(1);
            end
          end
          StWaitLock, StStable: begin
            if (state == StStable && locked_s && stab_cnt == StabLast) begin
              // Completion beats a coincident timeout.
              state     <= StRun;
              ready     <= 1'b1;
              sys_rst   <= 1'b0;
              retry_cnt <= '0;
            end else if (tmo_cnt == TmoLast) begin
              retry_cnt <= retry_inc;
              pll_rst   <= 1'b1;
`ifdef PLL_SEQ_FAULT_EN
              if (retry_inc >= RetryLimit) begin
                state   <= StFault;
                fault_q <= 1'b1;
              end else
`endif
              begin
                state    <= StResetHold;
                hold_cnt <= '0;
              end
            end else begin
              // Timeout keeps running across STABLE/WAIT_LOCK so chatter still times out.
              tmo_cnt <= tmo_cnt + TmoW'(1);
              if (state == StWaitLock) begin
                if (locked_s) begin
                  state    <= StStable;
                  stab_cnt <= '0;
                end
              end else if (!locked_s) begin
                state <= StWaitLock;
              end else begin
                stab_cnt <= stab_cnt + StabW'(1);
              end
            end
          end
          StRun: begin
            if (!locked_s) begin
              state     <= StResetHold;
              hold_cnt  <= '0;
              pll_rst   <= 1'b1;
              sys_rst   <= 1'b1;
              ready     <= 1'b0;
              lock_lost <= 1'b1;
            end
          end
`ifdef PLL_SEQ_FAULT_EN
          StFault: begin
            pll_rst <= 1'b1;
          end
`endif
          default: begin
            state    <= StResetHold;
            hold_cnt <= '0;
            pll_rst  <= 1'b1;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
